// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared configuration for the Sobol uniform generator.
// Holds datapath sizing, the direction-number type, the default direction table and the
// run FSM state encoding.
// Defaults: dimension 0 is van der Corput; dimensions 1..3 use the first Joe-Kuo primitive
// polynomials (s=1,a=0,m={1}), (s=2,a=1,m={1,3}), (s=3,a=1,m={1,3,1}). Dimensions beyond the
// tabulated set reuse the last polynomial.
package fpga_cfg_pkg;

    localparam int unsigned FP_WIDTH   = 32;
    localparam int unsigned FP_QFRAC   = 21;
    localparam int unsigned SOBOL_DIMS = 4;

    typedef logic [FP_QFRAC-1:0] sobol_dir_t;
    typedef sobol_dir_t [SOBOL_DIMS-1:0][FP_QFRAC-1:0] sobol_dir_tab_t;

    typedef enum logic {
        StIdle,
        StRun
    } sobol_state_e;

    // Direction number v[d][k] for a q-bit fraction: m_k scaled by 2^(q-1-k).
    function automatic logic [63:0] sobol_dir_entry(int unsigned d, int unsigned k,
                                                    int unsigned q);
        logic [63:0][63:0] m;
        logic [63:0]       res;
        int unsigned       s;
        int unsigned       a;
        m = '0;
        s = 1;
        a = 0;
        if (d == 0) begin
            res = 64'(1) << (q - 1 - k);
        end else begin
            case (d)
                1: begin
                    s = 1; a = 0; m[0] = 64'd1;
                end
                2: begin
                    s = 2; a = 1; m[0] = 64'd1; m[1] = 64'd3;
                end
                default: begin
                    s = 3; a = 1; m[0] = 64'd1; m[1] = 64'd3; m[2] = 64'd1;
                end
            endcase
            for (int unsigned i = s; i <= k; i++) begin
                m[i] = m[i-s] ^ (m[i-s] << s);
                for (int unsigned j = 1; j < s; j++) begin
                    if (a[s-1-j]) m[i] = m[i] ^ (m[i-j] << j);
                end
            end
            res = m[k] << (q - 1 - k);
        end
        return res;
    endfunction

    function automatic sobol_dir_tab_t sobol_dir_table();
        sobol_dir_tab_t tab;
        for (int unsigned d = 0; d < SOBOL_DIMS; d++) begin
            for (int unsigned k = 0; k < FP_QFRAC; k++) begin
                tab[d][k] = FP_QFRAC'(sobol_dir_entry(d, k, FP_QFRAC));
            end
        end
        return tab;
    endfunction

    localparam sobol_dir_tab_t SOBOL_DIR_DEFAULT = sobol_dir_table();

endpackage

// File: rtl/sobol_rzero.sv
// sobol_rzero: index of the rightmost zero bit of the Sobol point index.
// Ports:
//   idx  in  QFRAC          point index
//   pos  out $clog2(QFRAC)  position of lowest 0 bit; 0 when idx is all ones (that only
//                           occurs on the final point of a full-period run, whose update is
//                           never emitted)
module sobol_rzero
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned  QFRAC = FP_QFRAC,
    localparam int unsigned BitW  = $clog2(QFRAC)
) (
    input  logic [QFRAC-1:0] idx,
    output logic [BitW-1:0]  pos
);

    // Scan MSB to LSB so the lowest zero wins.
    always_comb begin
        pos = '0;
        for (int i = QFRAC - 1; i >= 0; i--) begin
            if (!idx[i]) pos = BitW'(i);
        end
    end

endmodule

// File: rtl/sobol_u_gen.sv
// sobol_u_gen: Gray-code Sobol generator producing Q11.21 uniform samples, one per
// dimension per point, round-robin over a valid/ready handshake.
// Optional feature macro: SOBOL_SKIP_ZERO_EN (run starts at point 1, never emits 0).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, npts         run request (IDLE only) and point count latched on accept
//   dir_we/dim/bit/val  direction-number write port (IDLE only)
//   ready_in            downstream accept
//   valid_out, u_out    sample valid, zero-extended x[dim]
//   dim_out             dimension of the current sample
//   busy, done, err     in RUN, end-of-run pulse, rejected-start pulse
module sobol_u_gen
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned  WIDTH = FP_WIDTH,
    parameter int unsigned  QFRAC = FP_QFRAC,
    parameter int unsigned  DIMS  = SOBOL_DIMS,
    localparam int unsigned DimW  = (DIMS > 1) ? $clog2(DIMS) : 1,
    localparam int unsigned BitW  = $clog2(QFRAC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [QFRAC:0]   npts,
    input  logic             dir_we,
    input  logic [DimW-1:0]  dir_dim,
    input  logic [BitW-1:0]  dir_bit,
    input  logic [QFRAC-1:0] dir_val,
    input  logic             ready_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] u_out,
    output logic [DimW-1:0]  dim_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef logic [DIMS-1:0][QFRAC-1:0][QFRAC-1:0] dir_tab_t;
    typedef logic [DIMS-1:0][QFRAC-1:0]            x_vec_t;

    // Same generator as SOBOL_DIR_DEFAULT, so default-sized builds reset to that table.
    function automatic dir_tab_t init_tab();
        dir_tab_t tab;
        for (int unsigned d = 0; d < DIMS; d++) begin
            for (int unsigned k = 0; k < QFRAC; k++) begin
                tab[d][k] = QFRAC'(sobol_dir_entry(d, k, QFRAC));
            end
        end
        return tab;
    endfunction

    localparam dir_tab_t DirInit = init_tab();

`ifdef SOBOL_SKIP_ZERO_EN
    localparam logic [QFRAC:0] PMax = {1'b0, {QFRAC{1'b1}}};
`else
    localparam logic [QFRAC:0] PMax = {1'b1, {QFRAC{1'b0}}};
`endif

    sobol_state_e     state_q, state_d;
    dir_tab_t         v_q, v_d;
    x_vec_t           x_q, x_d;
    logic [QFRAC-1:0] idx_q, idx_d;
    logic [DimW-1:0]  dim_q, dim_d;
    logic [QFRAC-1:0] pcnt_q, pcnt_d;
    logic [QFRAC:0]   npts_q, npts_d;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] u_q, u_d;
    logic [DimW-1:0]  dim_out_q, dim_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [BitW-1:0]  c_idx;
    logic             accept;
    logic             dir_in_range;

    sobol_rzero #(
        .QFRAC (QFRAC)
    ) u_rzero (
        .idx (idx_q),
        .pos (c_idx)
    );

    assign accept       = valid_q & ready_in;
    assign dir_in_range = (32'(dir_dim) < DIMS) && (32'(dir_bit) < QFRAC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            v_q       <= DirInit;
            x_q       <= '0;
            idx_q     <= '0;
            dim_q     <= '0;
            pcnt_q    <= '0;
            npts_q    <= '0;
            valid_q   <= 1'b0;
            u_q       <= '0;
            dim_out_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            x_q       <= x_d;
            idx_q     <= idx_d;
            dim_q     <= dim_d;
            pcnt_q    <= pcnt_d;
            npts_q    <= npts_d;
            valid_q   <= valid_d;
            u_q       <= u_d;
            dim_out_q <= dim_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        x_d     = x_q;
        idx_d   = idx_q;
        dim_d   = dim_q;
        pcnt_d  = pcnt_q;
        npts_d  = npts_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (dir_we && dir_in_range) begin
                    v_d[dir_dim][dir_bit] = dir_val;
                end
                // Run initialisation reads v_q, i.e. the table before any same-cycle write.
                if (start) begin
                    if (npts == '0) begin
                        done_d = 1'b1;
                    end else if (npts > PMax) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StRun;
                        npts_d  = npts;
                        dim_d   = '0;
                        pcnt_d  = '0;
`ifdef SOBOL_SKIP_ZERO_EN
                        for (int unsigned d = 0; d < DIMS; d++) begin
                            x_d[d] = v_q[d][0];
                        end
                        idx_d = QFRAC'(1);
`else
                        x_d   = '0;
                        idx_d = '0;
`endif
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    x_d[dim_q] = x_q[dim_q] ^ v_q[dim_q][c_idx];
                    if (dim_q == DimW'(DIMS - 1)) begin
                        dim_d  = '0;
                        idx_d  = idx_q + QFRAC'(1);
                        pcnt_d = pcnt_q + QFRAC'(1);
                        if (({1'b0, pcnt_q} + (QFRAC + 1)'(1)) == npts_q) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else begin
                        dim_d = dim_q + DimW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from next-state values so they change with the state.
    always_comb begin
        valid_d   = (state_d == StRun);
        busy_d    = (state_d == StRun);
        dim_out_d = '0;
        u_d       = '0;
        if (state_d == StRun) begin
            dim_out_d = dim_d;
            u_d       = WIDTH'(x_d[dim_d]);
        end
    end

    assign valid_out = valid_q;
    assign u_out     = u_q;
    assign dim_out   = dim_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sobol_u_gen.sv
// Self-checking bench for sobol_u_gen. The reference computes each sample directly as the
// XOR of direction numbers selected by the Gray code of the point index.
module tb_sobol_u_gen;
    import fpga_cfg_pkg::*;

`ifdef SOBOL_SKIP_ZERO_EN
    localparam int unsigned First = 1;
    localparam logic [21:0] PMaxTb = 22'h1FFFFF;
`else
    localparam int unsigned First = 0;
    localparam logic [21:0] PMaxTb = 22'h200000;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [21:0] npts;
    logic        dir_we;
    logic [1:0]  dir_dim;
    logic [4:0]  dir_bit;
    logic [20:0] dir_val;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] u_out;
    logic [1:0]  dim_out;
    logic        busy;
    logic        done;
    logic        err;

    int checks;
    int failures;

    logic [20:0] mdl_v [4][21];

    sobol_u_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .npts      (npts),
        .dir_we    (dir_we),
        .dir_dim   (dir_dim),
        .dir_bit   (dir_bit),
        .dir_val   (dir_val),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .u_out     (u_out),
        .dim_out   (dim_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_default();
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 21; k++) begin
                if (d == 0) mdl_v[d][k] = 21'(1) << (20 - k);
                else        mdl_v[d][k] = SOBOL_DIR_DEFAULT[d][k];
            end
        end
    endtask

    function automatic logic [20:0] mdl_x(input int unsigned n, input int unsigned d);
        logic [20:0] g;
        logic [20:0] r;
        g = 21'(n ^ (n >> 1));
        r = '0;
        for (int j = 0; j < 21; j++) begin
            if (g[j]) r = r ^ mdl_v[d][j];
        end
        return r;
    endfunction

    // Called and returns at posedge+1.
    task automatic dir_write(input int d, input int b, input logic [20:0] val);
        dir_we  = 1'b1;
        dir_dim = 2'(d);
        dir_bit = 5'(b);
        dir_val = val;
        @(posedge clk); #1;
        dir_we  = 1'b0;
        if (b < 21) mdl_v[d][b] = val;
    endtask

    // mode 0: always ready, 1: ready toggles starting at 1, 2: random ready plus ignored
    // start/dir_we traffic while running.
    task automatic run_points(input logic [21:0] np, input int mode);
        logic [20:0] exp_u[$];
        int          exp_d[$];
        int          cyc;
        logic        tog;
        for (int unsigned n = First; n < First + np; n++) begin
            for (int unsigned d = 0; d < 4; d++) begin
                exp_u.push_back(mdl_x(n, d));
                exp_d.push_back(int'(d));
            end
        end
        start = 1'b1;
        npts  = np;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        tog   = 1'b1;
        forever begin
            case (mode)
                0:       ready_in = 1'b1;
                1:       ready_in = tog;
                default: ready_in = 1'($urandom % 2);
            endcase
            tog = ~tog;
            if (mode == 2 && exp_u.size() > 0) begin
                start   = 1'($urandom % 2);
                npts    = 22'($urandom_range(1, 7));
                dir_we  = 1'b1;
                dir_dim = 2'($urandom % 4);
                dir_bit = 5'($urandom % 5);
                dir_val = 21'($urandom);
            end else begin
                start  = 1'b0;
                dir_we = 1'b0;
            end
            @(negedge clk);
            if (exp_u.size() == 0) begin
                chk("done_pulse", done, 1);
                chk("done_valid_low", valid_out, 0);
                chk("done_busy_low", busy, 0);
                break;
            end
            chk("run_valid", valid_out, 1);
            chk("run_u", u_out, {11'd0, exp_u[0]});
            chk("run_dim", dim_out, 32'(exp_d[0]));
            chk("run_no_done", done, 0);
            if (ready_in) begin
                void'(exp_u.pop_front());
                void'(exp_d.pop_front());
            end
            cyc++;
            if (cyc > 400) begin
                chk("run_timeout_remaining", 32'(exp_u.size()), 0);
                break;
            end
            @(posedge clk); #1;
        end
        ready_in = 1'b0;
        start    = 1'b0;
        dir_we   = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_done_low", done, 0);
        chk("post_valid_low", valid_out, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        start    = 1'b0;
        npts     = '0;
        dir_we   = 1'b0;
        dir_dim  = '0;
        dir_bit  = '0;
        dir_val  = '0;
        ready_in = 1'b0;
        load_default();

        // Reset state.
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", valid_out, 0);
        chk("rst_u", u_out, 0);
        chk("rst_dim", dim_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Default table, full-rate consumption.
        run_points(22'd4, 0);

        // Rewritten direction number, ready toggling 1/0.
        dir_write(1, 0, 21'h0AAAAA);
        run_points(22'd2, 1);

        // Zero points: done only.
        start = 1'b1;
        npts  = 22'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("npts0_done", done, 1);
        chk("npts0_valid", valid_out, 0);
        chk("npts0_busy", busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("npts0_done_clear", done, 0);
        chk("npts0_valid_after", valid_out, 0);
        @(posedge clk); #1;

        // One past the maximum point count: err only.
        start = 1'b1;
        npts  = PMaxTb + 22'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("over_err", err, 1);
        chk("over_busy", busy, 0);
        chk("over_valid", valid_out, 0);
        chk("over_done", done, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("over_err_clear", err, 0);
        chk("over_busy_after", busy, 0);
        @(posedge clk); #1;

        // Random table edits and randomized handshaking.
        for (int it = 0; it < 3; it++) begin
            for (int w = 0; w < 3; w++) begin
                dir_write(int'($urandom % 4), int'($urandom % 5), 21'($urandom));
            end
            dir_write(int'($urandom % 4), 21 + int'($urandom % 11), 21'($urandom));
            run_points(22'($urandom_range(1, 5)), 2);
        end

        // Asynchronous reset in the middle of a run.
        start    = 1'b1;
        npts     = 22'd5;
        ready_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_valid", valid_out, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_u", u_out, 0);
        chk("mid_rst_dim", dim_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        ready_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        load_default();
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        @(posedge clk); #1;
        run_points(22'd3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
